// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes, operand and
// write-back select encodings, and the decoded control bundle.
package rv32i_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ALU operation select (alu_ctrl[3:1]); values equal the RV32I funct3
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  // alu_ctrl[0]: turns ADD into SUB and SRL into SRA
  localparam logic ALU_MOD_SUB_SRA = 1'b1;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'b00,
    SRC_A_PC   = 2'b01,
    SRC_A_ZERO = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [3:0]  alu_ctrl;
    src_a_e      src_a;
    logic        src_b_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic [2:0]  funct3;
    wb_sel_e     wb_sel;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/rv32i_decoder_comb.sv
// Pure combinational RV32I instruction decoder.
// Optional macro RV32I_DECODE_ILLEGAL_CHECK_EN enables illegal-encoding
// detection; when undefined, illegal is tied 0 and controls follow the opcode.
module rv32i_decoder_comb
  import rv32i_pkg::*;
(
  input  logic [31:0] instr_i,
  output decoded_t    dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm_sh;
  logic        illegal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                   instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                   instr_i[30:21], 1'b0};
  // Shift-immediates carry only the 5-bit shift amount
  assign imm_sh = {27'b0, instr_i[24:20]};

`ifdef RV32I_DECODE_ILLEGAL_CHECK_EN
  logic [6:0] funct7;
  assign funct7 = instr_i[31:25];

  // Flag encodings outside the supported RV32I subset
  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: illegal = 1'b0;
      OPC_JALR:   illegal = (funct3 != 3'b000);
      OPC_BRANCH: illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      OPC_LOAD:   illegal = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                            (funct3 == 3'b111);
      OPC_STORE:  illegal = (funct3 >= 3'b011);
      OPC_OP_IMM: begin
        if (funct3 == ALU_SLL)
          illegal = (funct7 != 7'b0000000);
        else if (funct3 == ALU_SR)
          illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPC_OP: illegal = !((funct7 == 7'b0000000) ||
                          ((funct7 == 7'b0100000) &&
                           ((funct3 == ALU_ADD) || (funct3 == ALU_SR))));
      default: illegal = 1'b1;
    endcase
  end
`else
  assign illegal = 1'b0;
`endif

  // Opcode-driven control decode; illegal encodings lose all side effects
  always_comb begin
    dec_o           = '0;
    dec_o.rd        = instr_i[11:7];
    dec_o.rs1       = instr_i[19:15];
    dec_o.rs2       = instr_i[24:20];
    dec_o.funct3    = funct3;
    dec_o.src_a     = SRC_A_RS1;
    dec_o.wb_sel    = WB_ALU;
    dec_o.alu_ctrl  = {ALU_ADD, 1'b0};
    case (opcode)
      OPC_LUI: begin
        dec_o.imm       = imm_u;
        dec_o.src_a     = SRC_A_ZERO;
        dec_o.src_b_imm = 1'b1;
        dec_o.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec_o.imm       = imm_u;
        dec_o.src_a     = SRC_A_PC;
        dec_o.src_b_imm = 1'b1;
        dec_o.reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec_o.imm       = imm_j;
        dec_o.src_a     = SRC_A_PC;
        dec_o.src_b_imm = 1'b1;
        dec_o.reg_write = 1'b1;
        dec_o.jal       = 1'b1;
        dec_o.wb_sel    = WB_PC4;
      end
      OPC_JALR: begin
        dec_o.imm       = imm_i;
        dec_o.src_b_imm = 1'b1;
        dec_o.reg_write = 1'b1;
        dec_o.jalr      = 1'b1;
        dec_o.wb_sel    = WB_PC4;
      end
      OPC_BRANCH: begin
        dec_o.imm    = imm_b;
        dec_o.branch = 1'b1;
        case (funct3[2:1])
          2'b00:   dec_o.alu_ctrl = {ALU_ADD, ALU_MOD_SUB_SRA};
          2'b10:   dec_o.alu_ctrl = {ALU_SLT, 1'b0};
          2'b11:   dec_o.alu_ctrl = {ALU_SLTU, 1'b0};
          default: dec_o.alu_ctrl = {ALU_ADD, 1'b0};
        endcase
      end
      OPC_LOAD: begin
        dec_o.imm       = imm_i;
        dec_o.src_b_imm = 1'b1;
        dec_o.reg_write = 1'b1;
        dec_o.mem_read  = 1'b1;
        dec_o.wb_sel    = WB_MEM;
      end
      OPC_STORE: begin
        dec_o.imm       = imm_s;
        dec_o.src_b_imm = 1'b1;
        dec_o.mem_write = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_o.src_b_imm = 1'b1;
        dec_o.reg_write = 1'b1;
        if ((funct3 == ALU_SLL) || (funct3 == ALU_SR))
          dec_o.imm = imm_sh;
        else
          dec_o.imm = imm_i;
        // instr[30] is an immediate bit for ADDI, only a modifier for SRAI
        dec_o.alu_ctrl = {funct3, (funct3 == ALU_SR) & instr_i[30]};
      end
      OPC_OP: begin
        dec_o.reg_write = 1'b1;
        dec_o.alu_ctrl  = {funct3, instr_i[30]};
      end
      default: ;
    endcase
    dec_o.illegal = illegal;
    if (illegal) begin
      dec_o.reg_write = 1'b0;
      dec_o.mem_read  = 1'b0;
      dec_o.mem_write = 1'b0;
      dec_o.branch    = 1'b0;
      dec_o.jal       = 1'b0;
      dec_o.jalr      = 1'b0;
    end
  end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode pipeline stage: combinational decode into a registered output
// backed by a 2-entry skid buffer, valid/ready on both sides, flush to NOP.
// Optional macro RV32I_DECODE_ILLEGAL_CHECK_EN enables out_illegal.
module rv32i_decode_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_ctrl,
  output logic [1:0]      out_src_a,
  output logic            out_src_b_imm,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jal,
  output logic            out_jalr,
  output logic [2:0]      out_funct3,
  output logic [1:0]      out_wb_sel,
  output logic            out_illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } occ_e;

  occ_e            state_q, state_d;
  decoded_t        main_q, main_d;
  decoded_t        skid_q, skid_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            in_ready_q;

  decoded_t        in_dec;
  decoded_t        nop_dec;
  logic            accept;
  logic            pop;

  rv32i_decoder_comb u_dec (
    .instr_i (in_instr),
    .dec_o   (in_dec)
  );

  // Constant-input instance supplying the reset/flush payload
  rv32i_decoder_comb u_nop_dec (
    .instr_i (NOP_INSTR),
    .dec_o   (nop_dec)
  );

  assign accept = in_valid & in_ready_q;
  assign pop    = (state_q != ST_EMPTY) & out_ready;

  // Occupancy next-state and payload movement; flush overrides everything
  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    main_pc_d = main_pc_q;
    skid_d    = skid_q;
    skid_pc_d = skid_pc_q;
    if (flush) begin
      state_d   = ST_EMPTY;
      main_d    = nop_dec;
      main_pc_d = '0;
      skid_d    = nop_dec;
      skid_pc_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d    = in_dec;
            main_pc_d = in_pc;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_d    = in_dec;
            main_pc_d = in_pc;
          end else if (accept) begin
            skid_d    = in_dec;
            skid_pc_d = in_pc;
            state_d   = ST_TWO;
          end else if (pop) begin
            state_d   = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_d    = skid_q;
            main_pc_d = skid_pc_q;
            state_d   = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and payload registers; in_ready is precomputed so it never
  // depends combinationally on out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= nop_dec;
      main_pc_q  <= '0;
      skid_q     <= nop_dec;
      skid_pc_q  <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      main_pc_q  <= main_pc_d;
      skid_q     <= skid_d;
      skid_pc_q  <= skid_pc_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = (state_q != ST_EMPTY);
  assign out_pc        = main_pc_q;
  assign out_rd        = main_q.rd;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_imm       = main_q.imm;
  assign out_alu_ctrl  = main_q.alu_ctrl;
  assign out_src_a     = main_q.src_a;
  assign out_src_b_imm = main_q.src_b_imm;
  assign out_reg_write = main_q.reg_write;
  assign out_mem_read  = main_q.mem_read;
  assign out_mem_write = main_q.mem_write;
  assign out_branch    = main_q.branch;
  assign out_jal       = main_q.jal;
  assign out_jalr      = main_q.jalr;
  assign out_funct3    = main_q.funct3;
  assign out_wb_sel    = main_q.wb_sel;
  assign out_illegal   = main_q.illegal;

endmodule
